seg7_scan_display: RTL
======================

// Module: seg7_scan_display
// PURPOSE
//  Downstream consumer of the input-value rotator. Takes the rotated NDIG-nibble
//  value and drives a multiplexed, common-anode seven-segment display.
//  - Time-multiplexes the digits with a refresh divider.
//  - Decodes each nibble to hex glyphs.
//  - Buffers new values so that they only take effect at a frame boundary.
// PARAMETERS
//  NDIG        4      number of digits; val_in width = 4*NDIG
//  REFRESH_DIV 50000  clk cycles per digit slot (>= 8)
//  CNT_W       16     refresh counter width; must hold REFRESH_DIV-1
//  BLANK_CYC   4      anode-off cycles at slot start (used only with macro)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  val_in     in   4*NDIG  rotated value; nibble k shows on digit k (k=0 rightmost)
//  load       in   1       1-cycle strobe; capture val_in
//  an         out  NDIG    anode enables, active low
//  seg        out  7       segments {g,f,e,d,c,b,a}, active low
//  dp         out  1       decimal point, active low; held 1 (off)
//  frame_done out  1       1-cycle pulse when digit NDIG-1 slot ends
// BEHAVIOUR
//  - Reset values: an=all 1, seg=7'h7F, dp=1, frame_done=0. Internal state
//    cleared: ref_cnt=0, idx=0, disp_reg=0, pend_reg=0, pend=0.
//    Reset mid-frame aborts the scan immediately. No partial state survives.
//  - Refresh: ref_cnt counts 0..REFRESH_DIV-1 and then wraps to 0.
//    On the wrap, idx advances, with NDIG-1 -> 0.
//    frame_done=1 on the cycle ref_cnt wraps while idx==NDIG-1.
//  - Load: on load=1, val_in -> pend_reg and pend=1. A later load overwrites
//    pend_reg (last value wins).
//  - Commit: at the frame wrap, if pend=1 then disp_reg<=pend_reg and pend<=0.
//    If load and the frame wrap happen in the same cycle, the val_in of that
//    cycle is committed directly to disp_reg and pend=0. The display never
//    shows a torn (mixed-value) frame.
//  - Outputs are registered, 1-cycle latency from idx/disp_reg:
//    an = ~(1<<idx); seg = decode(disp_reg[4*idx+:4]).
//    First cycle after rst deasserts: an=...1110, seg shows nibble 0 of disp_reg.
//  - Decode, active low {g..a}:
//      0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//      6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011
//      C=1000110 d=0100001 E=0000110 F=0001110
//  - State machine: {SCAN, COMMIT}. COMMIT lasts exactly one cycle, on the
//    frame wrap when pend=1 or load=1; it then returns to SCAN. The scan
//    timing is unaffected by COMMIT.
// CONFIGURATION
//  SEG7_GHOST_BLANK_EN defined:
//    - For ref_cnt < BLANK_CYC in each slot, an=all 1 and seg=7'h7F.
//    - The digit is driven for the remaining REFRESH_DIV-BLANK_CYC cycles.
//  SEG7_GHOST_BLANK_EN undefined:
//    - No blanking; the digit is driven for the whole slot.
//    - BLANK_CYC is ignored.
// TESTING (sim: NDIG=4, REFRESH_DIV=8, BLANK_CYC=2)
//  1. Reset held 3 cycles, then released:
//     -> during reset an=1111, seg=7F, dp=1.
//     -> after release, an=1110 and seg=1000000.
//     -> an rotates 1110,1101,1011,0111 every 8 cycles.
//     -> frame_done pulses every 32 cycles.
//  2. load with val_in=16'h1A8F mid-frame:
//     -> the display is unchanged until the next frame_done.
//     -> next frame: digit0=0001110 (F), digit1=0000000 (8),
//        digit2=0001000 (A), digit3=1111001 (1).
//  3. Two loads in one frame, 16'h1111 then 16'h2222:
//     -> only 2222 is committed; seg=0100100 on all digits.
//  4. load of 16'h5555 on the exact frame-wrap cycle:
//     -> committed at once; the next frame shows 0010010 on all digits.
//  5. rst asserted at idx=2 with pend=1:
//     -> an=1111; pending value discarded.
//     -> after release, the display shows 0000 starting at digit 0.
//  6. SEG7_GHOST_BLANK_EN defined:
//     -> the first 2 cycles of each slot have an=1111, seg=7F.
//     -> the remaining 6 cycles drive the digit.
//     Undefined: no blank cycles.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode seven-segment driver with frame-boundary value commit.
// Optional anti-ghosting blank at slot start: define SEG7_GHOST_BLANK_EN.
module seg7_scan_display #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16,
    parameter int BLANK_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] val_in,
    input  logic              load,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              frame_done
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic {SCAN, COMMIT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   ref_cnt;
    logic [IDX_W-1:0]   idx;
    logic [4*NDIG-1:0]  disp_reg, pend_reg, commit_val, disp_shift;
    logic               pend, do_commit;
    logic               slot_wrap, frame_wrap, blank;
    logic [3:0]         digit;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'b1000000;
            4'h1: hex_decode = 7'b1111001;
            4'h2: hex_decode = 7'b0100100;
            4'h3: hex_decode = 7'b0110000;
            4'h4: hex_decode = 7'b0011001;
            4'h5: hex_decode = 7'b0010010;
            4'h6: hex_decode = 7'b0000010;
            4'h7: hex_decode = 7'b1111000;
            4'h8: hex_decode = 7'b0000000;
            4'h9: hex_decode = 7'b0010000;
            4'hA: hex_decode = 7'b0001000;
            4'hB: hex_decode = 7'b0000011;
            4'hC: hex_decode = 7'b1000110;
            4'hD: hex_decode = 7'b0100001;
            4'hE: hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    assign slot_wrap  = (ref_cnt == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx == IDX_LAST);

    // Commit happens on the wrap edge itself so digit 0 of the new frame already sees it.
    always_comb begin
        state_nxt  = SCAN;
        do_commit  = 1'b0;
        commit_val = pend_reg;
        case (state)
            SCAN: begin
                if (frame_wrap && (pend || load)) begin
                    state_nxt  = COMMIT;
                    do_commit  = 1'b1;
                    commit_val = load ? val_in : pend_reg;
                end
            end
            COMMIT: state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            ref_cnt  <= '0;
            idx      <= '0;
            disp_reg <= '0;
            pend_reg <= '0;
            pend     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ref_cnt <= slot_wrap ? '0 : ref_cnt + 1'b1;
            if (slot_wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (do_commit) begin
                disp_reg <= commit_val;
                pend     <= 1'b0;
            end else if (load) begin
                pend_reg <= val_in;
                pend     <= 1'b1;
            end
        end
    end

    assign disp_shift = disp_reg >> {idx, 2'b00};
    assign digit      = disp_shift[3:0];

`ifdef SEG7_GHOST_BLANK_EN
    assign blank = (ref_cnt < CNT_W'(BLANK_CYC));
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            an         <= blank ? '1 : ~(NDIG'(1) << idx);
            seg        <= blank ? 7'h7F : hex_decode(digit);
            frame_done <= frame_wrap;
        end
    end

    assign dp = 1'b1;

endmodule
